// File: rtl/regfile_scoreboard.sv
// Parametrised register file with same-cycle write bypass, a pending-write scoreboard
// for long-latency loads, and a registered debug probe port.
module regfile_scoreboard #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic              ren1,
   input  logic              ren2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              stall,
   output logic [ADDR_W:0]   pend_cnt,
   input  logic [ADDR_W-1:0] probe_addr,
   output logic [WIDTH-1:0]  probe_data
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
   localparam logic [WIDTH-1:0]  ZERO_DATA = {WIDTH{1'b0}};
   localparam logic              BYP       = (BYPASS != 0);

   logic [WIDTH-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0] pend_r;
   logic [DEPTH-1:0] pend_nxt_s;
   logic [ADDR_W:0]  pend_cnt_r;
   logic [WIDTH-1:0] probe_data_r;
   logic             wr_s;
   logic             iss_s;
   logic             fwd1_s;
   logic             fwd2_s;
   logic [WIDTH-1:0] rd1_s;
   logic [WIDTH-1:0] rd2_s;
   logic             stall_s;

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] n;
      n = {(ADDR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         n = n + {{ADDR_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Qualified write/issue strobes and read-port forwarding; register 0 is never a target.
   always_comb begin
      wr_s   = we & (wa != ZERO_ADDR);
      iss_s  = issue_en & (issue_addr != ZERO_ADDR);
      fwd1_s = BYP & wr_s & (wa == ra1);
      fwd2_s = BYP & wr_s & (wa == ra2);
   end

   // Combinational read ports with optional forwarding of the in-flight write.
   always_comb begin
      if (ra1 == ZERO_ADDR) begin
         rd1_s = ZERO_DATA;
      end else if (fwd1_s) begin
         rd1_s = wd;
      end else begin
         rd1_s = regs_r[ra1];
      end
      if (ra2 == ZERO_ADDR) begin
         rd2_s = ZERO_DATA;
      end else if (fwd2_s) begin
         rd2_s = wd;
      end else begin
         rd2_s = regs_r[ra2];
      end
   end

   // Next pending vector: a new issue overrides a writeback to the same register.
   always_comb begin
      pend_nxt_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         pend_nxt_s[i] = (iss_s & (issue_addr == ADDR_W'(i)))
                       | (pend_r[i] & ~(wr_s & (wa == ADDR_W'(i))));
      end
   end

   // Read-after-write hazard; pend_r[0] is always clear so address 0 never stalls.
   always_comb begin
      stall_s = (ren1 & pend_r[ra1] & ~fwd1_s) | (ren2 & pend_r[ra2] & ~fwd2_s);
   end

   // Register array storage; entry 0 is held at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= ZERO_DATA;
         end
      end else if (wr_s) begin
         regs_r[wa] <= wd;
      end
   end

   // Scoreboard, its population count and the probe capture (pre-write contents).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r       <= {DEPTH{1'b0}};
         pend_cnt_r   <= {(ADDR_W+1){1'b0}};
         probe_data_r <= ZERO_DATA;
      end else begin
         pend_r       <= pend_nxt_s;
         pend_cnt_r   <= popcount(pend_nxt_s);
         probe_data_r <= (probe_addr == ZERO_ADDR) ? ZERO_DATA : regs_r[probe_addr];
      end
   end

   assign rd1        = rd1_s;
   assign rd2        = rd2_s;
   assign stall      = stall_s;
   assign pend_cnt   = pend_cnt_r;
   assign probe_data = probe_data_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard: bypass/no-bypass 32x32 copies
// plus a 16x8 copy, all checked against an array-based reference model.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Shared stimulus for the two 32x32 instances
   logic [4:0]  ra1, ra2, wa, issue_addr, probe_addr;
   logic        ren1, ren2, we, issue_en;
   logic [31:0] wd;
   logic [31:0] rd1_b, rd2_b, probe_b, rd1_n, rd2_n, probe_n;
   logic        stall_b, stall_n;
   logic [5:0]  cnt_b, cnt_n;

   // 16x8 instance
   logic [2:0]  s_ra1, s_ra2, s_wa, s_ia, s_pa;
   logic        s_ren1, s_ren2, s_we, s_ie;
   logic [15:0] s_wd, s_rd1, s_rd2, s_probe;
   logic        s_stall;
   logic [3:0]  s_cnt;

   regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ren1(ren1), .ren2(ren2),
      .rd1(rd1_b), .rd2(rd2_b), .we(we), .wa(wa), .wd(wd), .issue_en(issue_en),
      .issue_addr(issue_addr), .stall(stall_b), .pend_cnt(cnt_b),
      .probe_addr(probe_addr), .probe_data(probe_b));

   regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ren1(ren1), .ren2(ren2),
      .rd1(rd1_n), .rd2(rd2_n), .we(we), .wa(wa), .wd(wd), .issue_en(issue_en),
      .issue_addr(issue_addr), .stall(stall_n), .pend_cnt(cnt_n),
      .probe_addr(probe_addr), .probe_data(probe_n));

   regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1)) u_small (
      .clk(clk), .reset(reset), .ra1(s_ra1), .ra2(s_ra2), .ren1(s_ren1), .ren2(s_ren2),
      .rd1(s_rd1), .rd2(s_rd2), .we(s_we), .wa(s_wa), .wd(s_wd), .issue_en(s_ie),
      .issue_addr(s_ia), .stall(s_stall), .pend_cnt(s_cnt),
      .probe_addr(s_pa), .probe_data(s_probe));

   // Reference model state
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   logic [31:0] m_probe;
   logic [15:0] sm_regs [8];
   bit          sm_pend [8];
   logic [15:0] sm_probe;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
      if (ra == 5'd0) return 32'd0;
      if (byp && we && wa == ra) return wd;
      return m_regs[ra];
   endfunction

   function automatic bit exp_stall(input bit byp);
      bit h1, h2;
      h1 = ren1 && m_pend[ra1] && !(byp && we && wa == ra1 && ra1 != 5'd0);
      h2 = ren2 && m_pend[ra2] && !(byp && we && wa == ra2 && ra2 != 5'd0);
      return h1 || h2;
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      foreach (m_pend[i]) n += int'(m_pend[i]);
      return n;
   endfunction

   function automatic logic [15:0] s_exp_rd(input logic [2:0] ra);
      if (ra == 3'd0) return 16'd0;
      if (s_we && s_wa == ra) return s_wd;
      return sm_regs[ra];
   endfunction

   function automatic bit s_exp_stall();
      bit h1, h2;
      h1 = s_ren1 && sm_pend[s_ra1] && !(s_we && s_wa == s_ra1 && s_ra1 != 3'd0);
      h2 = s_ren2 && sm_pend[s_ra2] && !(s_we && s_wa == s_ra2 && s_ra2 != 3'd0);
      return h1 || h2;
   endfunction

   function automatic int s_exp_cnt();
      int n = 0;
      foreach (sm_pend[i]) n += int'(sm_pend[i]);
      return n;
   endfunction

   task automatic model_reset();
      foreach (m_regs[i]) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
      foreach (sm_regs[i]) begin sm_regs[i] = 16'd0; sm_pend[i] = 1'b0; end
      m_probe  = 32'd0;
      sm_probe = 16'd0;
   endtask

   // Apply the rules of one rising edge to the model (inputs still stable).
   task automatic model_edge();
      m_probe  = (probe_addr == 5'd0) ? 32'd0 : m_regs[probe_addr];
      sm_probe = (s_pa == 3'd0) ? 16'd0 : sm_regs[s_pa];
      if (we && wa != 5'd0) begin m_regs[wa] = wd; m_pend[wa] = 1'b0; end
      if (issue_en && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
      if (s_we && s_wa != 3'd0) begin sm_regs[s_wa] = s_wd; sm_pend[s_wa] = 1'b0; end
      if (s_ie && s_ia != 3'd0) sm_pend[s_ia] = 1'b1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ":rd1_b"},   rd1_b,           exp_rd(ra1, 1'b1));
      check({tag, ":rd2_b"},   rd2_b,           exp_rd(ra2, 1'b1));
      check({tag, ":rd1_n"},   rd1_n,           exp_rd(ra1, 1'b0));
      check({tag, ":rd2_n"},   rd2_n,           exp_rd(ra2, 1'b0));
      check({tag, ":stall_b"}, 32'(stall_b),    32'(exp_stall(1'b1)));
      check({tag, ":stall_n"}, 32'(stall_n),    32'(exp_stall(1'b0)));
      check({tag, ":cnt_b"},   32'(cnt_b),      32'(exp_cnt()));
      check({tag, ":cnt_n"},   32'(cnt_n),      32'(exp_cnt()));
      check({tag, ":probe_b"}, probe_b,         m_probe);
      check({tag, ":probe_n"}, probe_n,         m_probe);
      check({tag, ":s_rd1"},   32'(s_rd1),      32'(s_exp_rd(s_ra1)));
      check({tag, ":s_rd2"},   32'(s_rd2),      32'(s_exp_rd(s_ra2)));
      check({tag, ":s_stall"}, 32'(s_stall),    32'(s_exp_stall()));
      check({tag, ":s_cnt"},   32'(s_cnt),      32'(s_exp_cnt()));
      check({tag, ":s_probe"}, 32'(s_probe),    32'(sm_probe));
   endtask

   task automatic idle();
      ra1 = 5'd0; ra2 = 5'd0; ren1 = 1'b0; ren2 = 1'b0; we = 1'b0; wa = 5'd0;
      wd = 32'd0; issue_en = 1'b0; issue_addr = 5'd0; probe_addr = 5'd0;
      s_ra1 = 3'd0; s_ra2 = 3'd0; s_ren1 = 1'b0; s_ren2 = 1'b0; s_we = 1'b0;
      s_wa = 3'd0; s_wd = 16'd0; s_ie = 1'b0; s_ia = 3'd0; s_pa = 3'd0;
   endtask

   // Called just after the falling edge with inputs applied.
   task automatic step(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      ra1 = 5'd16;
      #1 check_all("por");
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of operation
      idle(); we = 1'b1; wa = 5'd16; wd = 32'h0000_09A3; issue_en = 1'b1; issue_addr = 5'd5;
      step("mid_setup");
      idle(); ra1 = 5'd16; ren1 = 1'b1;
      #1 check("pre_rst_rd1", rd1_b, 32'h0000_09A3);
      reset = 1'b1;
      #1 check("rst_rd1", rd1_b, 32'd0);
      check("rst_cnt", 32'(cnt_b), 32'd0);
      ra1 = 5'd5;
      #1 check("rst_stall", 32'(stall_b), 32'd0);
      model_reset();
      check_all("in_rst");
      reset = 1'b0;
      @(posedge clk);
      model_edge();
      @(negedge clk);

      // Zero register and plain write/read/probe
      idle(); we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; step("w0");
      idle(); we = 1'b1; wa = 5'd3; wd = 32'h1234_5678; step("w3");
      idle(); ra1 = 5'd0; ra2 = 5'd3; probe_addr = 5'd3;
      #1 check("zero_rd1", rd1_b, 32'd0);
      check("w3_rd2", rd2_b, 32'h1234_5678);
      step("rd3");
      idle(); probe_addr = 5'd3;
      #1 check("probe3", probe_b, 32'h1234_5678);
      step("probe");

      // Bypass versus no bypass
      idle(); we = 1'b1; wa = 5'd7; wd = 32'h1111_1111; step("w7a");
      idle(); we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; ra1 = 5'd7;
      #1 check("byp_rd1", rd1_b, 32'hA5A5_A5A5);
      check("nobyp_rd1", rd1_n, 32'h1111_1111);
      step("w7b");

      // Load-use stall
      idle(); issue_en = 1'b1; issue_addr = 5'd9; step("iss9");
      idle(); ra2 = 5'd9; ren2 = 1'b1;
      #1 check("lu_stall", 32'(stall_b), 32'd1);
      check("lu_cnt", 32'(cnt_b), 32'd1);
      step("lu");
      idle(); ra2 = 5'd9;
      #1 check("lu_noren", 32'(stall_b), 32'd0);
      step("lu_noren");
      idle(); ra2 = 5'd9; ren2 = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h42;
      #1 check("wb_stall_b", 32'(stall_b), 32'd0);
      check("wb_stall_n", 32'(stall_n), 32'd1);
      check("wb_rd2", rd2_b, 32'h42);
      step("wb9");
      idle();
      #1 check("wb_cnt", 32'(cnt_b), 32'd0);

      // Simultaneous issue and writeback, then several pending
      idle(); issue_en = 1'b1; issue_addr = 5'd4; step("iss4");
      idle(); issue_en = 1'b1; issue_addr = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h44;
      step("iss_wb4");
      idle(); ra1 = 5'd4; ren1 = 1'b1;
      #1 check("p4_stall", 32'(stall_b), 32'd1);
      check("p4_cnt", 32'(cnt_b), 32'd1);
      idle(); issue_en = 1'b1; issue_addr = 5'd5; step("iss5");
      idle(); issue_en = 1'b1; issue_addr = 5'd6; step("iss6");
      idle();
      #1 check("cnt3", 32'(cnt_b), 32'd3);
      we = 1'b1; wa = 5'd5; wd = 32'h55; step("wb5");
      idle();
      #1 check("cnt2", 32'(cnt_b), 32'd2);

      // Small instance: fill the scoreboard and write the top address
      for (int i = 1; i < 8; i++) begin
         idle(); s_ie = 1'b1; s_ia = 3'(i); step("s_iss");
      end
      idle();
      #1 check("s_cnt7", 32'(s_cnt), 32'd7);
      s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF; step("s_w7");
      idle(); s_ra1 = 3'd7;
      #1 check("s_rd7", 32'(s_rd1), 32'h0000_BEEF);
      step("s_rd7");

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         ra1 = rnd_addr(); ra2 = rnd_addr(); wa = rnd_addr();
         issue_addr = rnd_addr(); probe_addr = rnd_addr();
         ren1 = 1'($urandom_range(0, 1)); ren2 = 1'($urandom_range(0, 1));
         we = ($urandom_range(0, 1) == 1); issue_en = ($urandom_range(0, 4) < 2);
         wd = $urandom;
         s_ra1 = 3'($urandom_range(0, 7)); s_ra2 = 3'($urandom_range(0, 7));
         s_wa = 3'($urandom_range(0, 7)); s_ia = 3'($urandom_range(0, 7));
         s_pa = 3'($urandom_range(0, 7));
         s_ren1 = 1'($urandom_range(0, 1)); s_ren2 = 1'($urandom_range(0, 1));
         s_we = ($urandom_range(0, 1) == 1); s_ie = ($urandom_range(0, 4) < 2);
         s_wd = 16'($urandom);
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the next-generation CPU datapath. Generalises the fixed 32x32 file to configurable width and depth.
- Adds asynchronous reset, optional write-to-read bypass and a registered debug probe port.
- Adds a pending-write scoreboard, so multi-cycle memory loads can write back later while the issue stage stalls on read-after-write hazards.
- Sits between the instruction decoder and the ALU/data-memory writeback mux.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers. Must be a power of 2 and at least 2.
- ADDR_W, 5, address width. Must equal log2(DEPTH).
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports and clears that port's stall.

Ports:
- clk  input  1  clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state
- ra1  input  ADDR_W  read address, port 1
- ra2  input  ADDR_W  read address, port 2
- ren1  input  1  port 1 read is used this cycle (qualifies stall)
- ren2  input  1  port 2 read is used this cycle (qualifies stall)
- rd1  output  WIDTH  read data, port 1 (combinational)
- rd2  output  WIDTH  read data, port 2 (combinational)
- we  input  1  write enable / writeback strobe
- wa  input  ADDR_W  write address
- wd  input  WIDTH  write data
- issue_en  input  1  a long-latency write to issue_addr has been issued
- issue_addr  input  ADDR_W  destination of the issued write
- stall  output  1  a used read port targets a pending register
- pend_cnt  output  ADDR_W+1  number of registers currently pending
- probe_addr  input  ADDR_W  debug register select
- probe_data  output  WIDTH  registered contents of probe_addr

Behaviour:
- Reset (asynchronous, takes effect immediately on assertion):
  - all registers cleared to 0; all pending bits cleared to 0.
  - pend_cnt=0, probe_data=0.
  - stall is 0 during and after reset until the first issue.
- Register 0:
  - always reads 0.
  - writes to it are ignored.
  - issue_en with issue_addr=0 is ignored; register 0 is never pending.
- Write: at rising clk edge, when we=1 and wa!=0, regs[wa] takes wd. The new value is visible on rd1/rd2 (non-bypass path) in the following cycle.
- Read:
  - rd1/rd2 are combinational from ra1/ra2.
  - With BYPASS=1, a read port returns wd instead of the stored value when we=1, wa==ra and ra!=0.
  - With BYPASS=0, a read in the same cycle as a write returns the old value.
- Scoreboard, per-register pending bit p[i], updated at rising clk edge:
  - we=1 and wa!=0: clear p[wa].
  - issue_en=1 and issue_addr!=0: set p[issue_addr].
  - Both in the same cycle to the same address: set wins, and the register stays pending for the new issue.
  - Issue to a register that is already pending: it stays pending (no counting, no error).
  - Write to a register that is not pending: normal write; p is unchanged.
- stall, combinational: stall = (ren1 & hit1) | (ren2 & hit2).
  - hitN = p[raN] & !(BYPASS & we & wa==raN).
  - ra=0 never hits.
- pend_cnt: registered population count of p, updated in the same edge as p. Range 0..DEPTH-1.
- probe_data: 1-cycle latency. At each edge it captures regs[probe_addr] as it stands before any write in that edge (no bypass). Register 0 probes 0.
- No illegal states. Every address value is legal.

Test Plan:
- Reset mid-operation: write regs[16]=0x000009A3, assert issue_en to reg 5, then pulse reset between edges → rd1(ra1=16)=0 immediately; pend_cnt=0 and stall=0 with ren1=1, ra1=5.
- Write/read and zero register: we=1, wa=0, wd=0xFFFFFFFF, then wa=3, wd=0x12345678 → next cycle rd1(ra1=0)=0 and rd2(ra2=3)=0x12345678; probe_addr=3 gives probe_data=0x12345678 one cycle later.
- Bypass: BYPASS=1, we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle → rd1=0xA5A5A5A5 before the edge. With BYPASS=0 → rd1 equals the previous value of regs[7].
- Load-use stall: issue_en to reg 9; next cycle ra2=9, ren2=1 → stall=1 and pend_cnt=1. With ren2=0 → stall=0. Writeback we=1, wa=9, wd=0x42 → stall=0 that cycle (BYPASS=1) and rd2=0x42; pend_cnt=0 after the edge.
- Simultaneous issue and writeback to reg 4 in the same edge → p[4] stays 1 and pend_cnt is unchanged. Issue to 4, 5 and 6, then write back 5 → pend_cnt goes 3, then 2.
- Parameter sweep: WIDTH=16, DEPTH=8 → a write to address 7 with 0xBEEF reads back 0xBEEF; pend_cnt reaches 7 when all of registers 1..7 are issued.
